// File: rtl/present_pkg.sv
// Shared PRESENT round definitions: S-box table, bit permutation and sequencer states.
package present_pkg;

    localparam int NIBBLES = 16;

    // Nibble 0 of the table sits in the most-significant position.
    localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[4*(15 - int'(x)) +: 4];
    endfunction

    // Bit i moves to 16*(i mod 4) + i/4.
    function automatic logic [63:0] player(input logic [63:0] d);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            p[16*(i % 4) + i/4] = d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/present_sbox_keyadd_dup.sv
// One nibble lane: two independent S-box + key-add copies with a disagreement flag.
(* keep_hierarchy = "yes", dont_touch = "true" *)
module present_sbox_keyadd_dup
    import present_pkg::*;
(
    input  logic [3:0] state_nib,
    input  logic [3:0] key_nib,
    output logic [3:0] out_nib,
    output logic       mismatch
);

    // Copy 1 sees buffered operands so the two copies cannot be merged.
    (* keep = "true", dont_touch = "true" *) logic [3:0] state_buf;
    (* keep = "true", dont_touch = "true" *) logic [3:0] key_buf;
    (* keep = "true", dont_touch = "true" *) logic [3:0] sb0;
    (* keep = "true", dont_touch = "true" *) logic [3:0] sb1;
    (* keep = "true", dont_touch = "true" *) logic [3:0] res0;
    (* keep = "true", dont_touch = "true" *) logic [3:0] res1;

    assign state_buf = state_nib;
    assign key_buf   = key_nib;

    assign sb0 = sbox(state_nib);
    assign sb1 = sbox(state_buf);

    assign res0 = sb0 ^ key_nib;
    assign res1 = sb1 ^ key_buf;

    assign out_nib  = res0;
    assign mismatch = (|(sb0 ^ sb1)) | (|(res0 ^ res1));

endmodule

// File: rtl/present_nibble_round_ctrl.sv
// PRESENT round sequencer: streams PAR nibbles per cycle through duplicated lanes,
// then presents pLayer of the accumulated result; lane disagreement locks into FAULT.
module present_nibble_round_ctrl
    import present_pkg::*;
#(
    parameter int PAR = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        fault,
    input  logic        fault_clear,
    output logic        busy
);

    localparam int GROUPS = NIBBLES / PAR;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      st_q, st_d;
    logic [63:0]      key_q, key_d;
    logic [63:0]      acc_q, acc_d;
    logic             fault_q, fault_d;

    logic [4*PAR-1:0] lane_state;
    logic [4*PAR-1:0] lane_key;
    logic [4*PAR-1:0] lane_out;
    logic [PAR-1:0]   lane_mis;

    assign lane_state = st_q[int'(cnt_q)*4*PAR +: 4*PAR];
    assign lane_key   = key_q[int'(cnt_q)*4*PAR +: 4*PAR];

    for (genvar j = 0; j < PAR; j++) begin : g_lane
        present_sbox_keyadd_dup u_lane (
            .state_nib (lane_state[4*j +: 4]),
            .key_nib   (lane_key[4*j +: 4]),
            .out_nib   (lane_out[4*j +: 4]),
            .mismatch  (lane_mis[j])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            acc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            key_q   <= key_d;
            acc_q   <= acc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_d      = st_q;
        key_d     = key_q;
        acc_d     = acc_q;
        fault_d   = fault_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_state;
                    key_d   = in_key;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (|lane_mis) begin
                    // Drop the whole partial result so nothing faulty can ever escape.
                    acc_d   = '0;
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    acc_d[int'(cnt_q)*4*PAR +: 4*PAR] = lane_out;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = player(acc_q);
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    fault_d = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_present_nibble_round_ctrl.sv
// Directed bench for the PRESENT round sequencer with a queue-based result scoreboard.
module tb_present_nibble_round_ctrl;

    localparam int PAR    = 4;
    localparam int GROUPS = 16 / PAR;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_state = '0;
    logic [63:0] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        fault;
    logic        fault_clear = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    logic [3:0] sb_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_nibble_round_ctrl #(.PAR(PAR)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .in_key      (in_key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .fault       (fault),
        .fault_clear (fault_clear),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [63:0] st, input logic [63:0] ky);
        logic [63:0] a;
        logic [63:0] p;
        for (int n = 0; n < 16; n++) a[4*n +: 4] = sb_t[st[4*n +: 4]] ^ ky[4*n +: 4];
        // Output bit q is fed from input bit 4*(q mod 16) + q/16.
        for (int q = 0; q < 64; q++) p[q] = a[4*(q % 16) + q/16];
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_fault"}, 64'(fault), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_round(input logic [63:0] st, input logic [63:0] ky, input int stall,
                            output logic [63:0] got);
        int lat;
        logic [63:0] expv;
        check("accept_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_state = st;
        in_key   = ky;
        exp_q.push_back(model(st, ky));
        @(negedge clock);
        in_valid = 1'b0;
        in_state = {$urandom, $urandom};
        in_key   = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 64'(lat), 64'(GROUPS + 1));
        got = out_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            check("stall_hold", out_data, got);
        end
        out_ready = 1'b1;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        check("round_data", out_data, expv);
        @(negedge clock);
        out_ready = 1'b0;
        check("back_idle", 64'(in_ready), 64'd1);
        check("idle_zero", out_data, 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        int acc_n;
        int done_n;
        int cyc;
        int last;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("reset");

        do_round(64'd0, 64'd0, 2, got);
        check("zero_vec", got, 64'hFFFFFFFF00000000);
        do_round(64'd0, 64'hFFFFFFFFFFFFFFFF, 0, got);
        check("ones_key_vec", got, 64'h00000000FFFFFFFF);

        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        check_idle_outputs("clear_in_idle");

        for (int r = 0; r < 1000; r++) begin
            do_round({$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, got);
        end

        // Lane copy 1 disagrees while the third nibble group is processed.
        in_valid = 1'b1;
        in_state = '0;
        in_key   = '0;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        force dut.g_lane[0].u_lane.res1 = 4'h0;
        @(negedge clock);
        release dut.g_lane[0].u_lane.res1;
        check("fault_set", 64'(fault), 64'd1);
        check("fault_busy", 64'(busy), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("fault_in_ready", 64'(in_ready), 64'd0);
            check("fault_out_valid", 64'(out_valid), 64'd0);
            check("fault_out_data", out_data, 64'd0);
            check("fault_sticky", 64'(fault), 64'd1);
            @(negedge clock);
        end
        in_valid = 1'b0;
        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        check_idle_outputs("fault_cleared");
        do_round(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1, got);

        // Reset in the middle of a round.
        in_valid = 1'b1;
        in_state = 64'h5555AAAA5555AAAA;
        in_key   = 64'h1234123412341234;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("mid_run_reset");
        do_round(64'd0, 64'd0, 0, got);
        check("post_reset_vec", got, 64'hFFFFFFFF00000000);

        // Back-to-back rounds with the consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = {$urandom, $urandom};
        in_key    = {$urandom, $urandom};
        acc_n = 0;
        done_n = 0;
        cyc = 0;
        last = -1;
        while (done_n < 4 && cyc < 200) begin
            if (out_valid) begin
                check("b2b_done_not_ready", 64'(in_ready), 64'd0);
                check("b2b_data", out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX);
                done_n++;
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(model(in_state, in_key));
                if (last >= 0) check("b2b_period", 64'(cyc - last), 64'(GROUPS + 2));
                last = cyc;
                acc_n++;
            end
            @(negedge clock);
            cyc++;
            in_valid = (acc_n < 4);
            in_state = {$urandom, $urandom};
            in_key   = {$urandom, $urandom};
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_rounds", 64'(done_n), 64'd4);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
